// File: rtl/cond_commit_stage.sv
`default_nettype none
// ============================================================================
//  Module      : cond_commit_stage
//  Description : Conditional-execution / commit stage between execute and
//                memory. Evaluates the ARM condition field against the
//                architectural NZCV flags, updates the flags for executed
//                flag-setting instructions and registers the gated write
//                enables plus data into the M-stage pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_commit_stage #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [31:0] ALUResult,
   input  logic [3:0]  ALUFlags,
   input  logic [3:0]  Cond,
   input  logic [1:0]  FlagW,
   input  logic        PCS,
   input  logic        RegW,
   input  logic        MemW,
   input  logic        NoWrite,
   input  logic [3:0]  WA3,
   input  logic [31:0] WriteData,
   output logic        ValidM,
   output logic        PCSrcM,
   output logic        RegWriteM,
   output logic        MemWriteM,
   output logic [31:0] ResultM,
   output logic [31:0] WriteDataM,
   output logic [3:0]  WA3M,
   output logic [3:0]  Flags,
   output logic        CondEx
);

   // Architectural flags and M-stage pipeline register
   logic [3:0]  flags_q,  flags_d;
   logic        valid_q,  valid_d;
   logic        pcs_q,    pcs_d;
   logic        regw_q,   regw_d;
   logic        memw_q,   memw_d;
   logic [31:0] result_q, result_d;
   logic [31:0] wdata_q,  wdata_d;
   logic [3:0]  wa3_q,    wa3_d;

   logic        flag_n, flag_z, flag_c, flag_v;
   logic        cond_ex;
   logic        accept;
   logic        exec;

   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_c = flags_q[1];
   assign flag_v = flags_q[0];

   // Condition decode against the registered flags only (never ALUFlags),
   // so an instruction sees the flags written by its predecessor
   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = ~flag_z;
         4'b0010: cond_ex = flag_c;
         4'b0011: cond_ex = ~flag_c;
         4'b0100: cond_ex = flag_n;
         4'b0101: cond_ex = ~flag_n;
         4'b0110: cond_ex = flag_v;
         4'b0111: cond_ex = ~flag_v;
         4'b1000: cond_ex = flag_c & ~flag_z;
         4'b1001: cond_ex = ~flag_c | flag_z;
         4'b1010: cond_ex = (flag_n == flag_v);
         4'b1011: cond_ex = (flag_n != flag_v);
         4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ex = flag_z | (flag_n != flag_v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;  // 1111: never executes
      endcase
   end

   assign accept = in_valid & ~stall & ~flush;
   assign exec   = accept & cond_ex;

   // Next-state for flags and the M-stage register; flush clears only the
   // control bits so the data fields keep their last captured values
   always_comb begin
      flags_d  = flags_q;
      valid_d  = valid_q;
      pcs_d    = pcs_q;
      regw_d   = regw_q;
      memw_d   = memw_q;
      result_d = result_q;
      wdata_d  = wdata_q;
      wa3_d    = wa3_q;

      if (exec && FlagW[1]) begin
         flags_d[3:2] = ALUFlags[3:2];
      end
      if (exec && FlagW[0]) begin
         flags_d[1:0] = ALUFlags[1:0];
      end

      if (flush) begin
         valid_d = 1'b0;
         pcs_d   = 1'b0;
         regw_d  = 1'b0;
         memw_d  = 1'b0;
      end else if (!stall) begin
         valid_d  = in_valid;
         regw_d   = exec & RegW & ~NoWrite;
         memw_d   = exec & MemW;
         pcs_d    = exec & PCS;
         result_d = ALUResult;
         wdata_d  = WriteData;
         wa3_d    = WA3;
      end
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q  <= RESET_FLAGS;
         valid_q  <= 1'b0;
         pcs_q    <= 1'b0;
         regw_q   <= 1'b0;
         memw_q   <= 1'b0;
         result_q <= 32'h0;
         wdata_q  <= 32'h0;
         wa3_q    <= 4'h0;
      end else begin
         flags_q  <= flags_d;
         valid_q  <= valid_d;
         pcs_q    <= pcs_d;
         regw_q   <= regw_d;
         memw_q   <= memw_d;
         result_q <= result_d;
         wdata_q  <= wdata_d;
         wa3_q    <= wa3_d;
      end
   end

   assign Flags      = flags_q;
   assign CondEx     = cond_ex;
   assign ValidM     = valid_q;
   assign PCSrcM     = pcs_q;
   assign RegWriteM  = regw_q;
   assign MemWriteM  = memw_q;
   assign ResultM    = result_q;
   assign WriteDataM = wdata_q;
   assign WA3M       = wa3_q;

endmodule
`default_nettype wire

// File: tb/tb_cond_commit_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cond_commit_stage
//  Description : Self-checking bench for cond_commit_stage: vector table with
//                hand-derived expectations, a scoreboard queue, and directed
//                stall / reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_commit_stage;

   localparam logic [3:0] RF = 4'b0000;

   logic        clk;
   logic        reset;
   logic        stall, flush, in_valid;
   logic [31:0] ALUResult, WriteData;
   logic [3:0]  ALUFlags, Cond, WA3;
   logic [1:0]  FlagW;
   logic        PCS, RegW, MemW, NoWrite;
   logic        ValidM, PCSrcM, RegWriteM, MemWriteM, CondEx;
   logic [31:0] ResultM, WriteDataM;
   logic [3:0]  WA3M, Flags;

   int n_checks = 0;
   int n_fail   = 0;

   cond_commit_stage #(.RESET_FLAGS(RF)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .ALUResult(ALUResult), .ALUFlags(ALUFlags),
      .Cond(Cond), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
      .NoWrite(NoWrite), .WA3(WA3), .WriteData(WriteData),
      .ValidM(ValidM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
      .MemWriteM(MemWriteM), .ResultM(ResultM), .WriteDataM(WriteDataM),
      .WA3M(WA3M), .Flags(Flags), .CondEx(CondEx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall, flush, valid;
      logic [31:0] alu;
      logic [3:0]  aluf, cond;
      logic [1:0]  flagw;
      logic        pcs, regw, memw, nowrite;
      logic [3:0]  wa3;
      logic        e_cx, e_v, e_rw, e_mw, e_pc;
      logic [31:0] e_res;
      logic [3:0]  e_wa3, e_fl;
   } vec_t;

   typedef struct {
      logic        v, rw, mw, pc;
      logic [31:0] res, wd;
      logic [3:0]  wa3, fl;
      string       tag;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %0s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one vector at posedge+1, check CondEx, then check outputs after the edge
   task automatic run_vec(input vec_t v, input string tag);
      exp_t e;
      stall     = v.stall;   flush = v.flush;   in_valid = v.valid;
      ALUResult = v.alu;     WriteData = ~v.alu;
      ALUFlags  = v.aluf;    Cond  = v.cond;    FlagW = v.flagw;
      PCS = v.pcs; RegW = v.regw; MemW = v.memw; NoWrite = v.nowrite;
      WA3 = v.wa3;
      e.v = v.e_v; e.rw = v.e_rw; e.mw = v.e_mw; e.pc = v.e_pc;
      e.res = v.e_res; e.wd = ~v.e_res; e.wa3 = v.e_wa3; e.fl = v.e_fl;
      e.tag = tag;
      sb.push_back(e);
      #1;
      chk({tag, "_condex"}, {31'h0, CondEx}, {31'h0, v.e_cx});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'h1, 32'h0);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_valid"},  {31'h0, ValidM},    {31'h0, e.v});
         chk({e.tag, "_regw"},   {31'h0, RegWriteM}, {31'h0, e.rw});
         chk({e.tag, "_memw"},   {31'h0, MemWriteM}, {31'h0, e.mw});
         chk({e.tag, "_pcsrc"},  {31'h0, PCSrcM},    {31'h0, e.pc});
         chk({e.tag, "_result"}, ResultM,            e.res);
         chk({e.tag, "_wdata"},  WriteDataM,         e.wd);
         chk({e.tag, "_wa3"},    {28'h0, WA3M},      {28'h0, e.wa3});
         chk({e.tag, "_flags"},  {28'h0, Flags},     {28'h0, e.fl});
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"},  {31'h0, ValidM},    32'h0);
      chk({tag, "_regw"},   {31'h0, RegWriteM}, 32'h0);
      chk({tag, "_memw"},   {31'h0, MemWriteM}, 32'h0);
      chk({tag, "_pcsrc"},  {31'h0, PCSrcM},    32'h0);
      chk({tag, "_result"}, ResultM,            32'h0);
      chk({tag, "_wdata"},  WriteDataM,         32'h0);
      chk({tag, "_wa3"},    {28'h0, WA3M},      32'h0);
      chk({tag, "_flags"},  {28'h0, Flags},     {28'h0, RF});
   endtask

   initial begin
      vec_t v;
      //         st fl va alu            aluf     cond     fw    pc rw mw nw wa3    cx v  rw mw pc res            wa3    flags
      tbl[0]  = '{0,0,1,32'h5,          4'b0100, 4'b1110, 2'b11, 0,1,0,0, 4'd3,  1, 1,1,0,0, 32'h5,          4'd3,  4'b0100};
      tbl[1]  = '{0,0,1,32'h10,         4'b0000, 4'b0000, 2'b00, 0,0,1,0, 4'd1,  1, 1,0,1,0, 32'h10,         4'd1,  4'b0100};
      tbl[2]  = '{0,0,1,32'h20,         4'b0000, 4'b0001, 2'b00, 0,0,1,0, 4'd2,  0, 1,0,0,0, 32'h20,         4'd2,  4'b0100};
      tbl[3]  = '{0,0,1,32'h30,         4'b1000, 4'b1110, 2'b11, 0,1,0,1, 4'd4,  1, 1,0,0,0, 32'h30,         4'd4,  4'b1000};
      tbl[4]  = '{0,0,1,32'h40,         4'b0000, 4'b1011, 2'b00, 1,0,0,0, 4'd15, 1, 1,0,0,1, 32'h40,         4'd15, 4'b1000};
      tbl[5]  = '{0,0,1,32'h50,         4'b0011, 4'b1111, 2'b11, 1,1,1,0, 4'd5,  0, 1,0,0,0, 32'h50,         4'd5,  4'b1000};
      tbl[6]  = '{0,0,0,32'h60,         4'b0110, 4'b1110, 2'b11, 1,1,1,0, 4'd6,  1, 0,0,0,0, 32'h60,         4'd6,  4'b1000};
      tbl[7]  = '{0,0,1,32'h70,         4'b1111, 4'b1000, 2'b01, 0,1,0,0, 4'd7,  0, 1,0,0,0, 32'h70,         4'd7,  4'b1000};
      tbl[8]  = '{0,0,1,32'h80,         4'b1111, 4'b1010, 2'b11, 0,1,0,0, 4'd8,  0, 1,0,0,0, 32'h80,         4'd8,  4'b1000};
      tbl[9]  = '{0,0,1,32'h90,         4'b0111, 4'b0100, 2'b01, 0,1,0,0, 4'd9,  1, 1,1,0,0, 32'h90,         4'd9,  4'b1011};
      tbl[10] = '{0,0,1,32'h3F80_0000,  4'b0100, 4'b0110, 2'b10, 0,0,1,0, 4'd10, 1, 1,0,1,0, 32'h3F80_0000,  4'd10, 4'b0111};
      tbl[11] = '{0,0,1,32'hB0,         4'b1000, 4'b1100, 2'b11, 0,1,0,0, 4'd11, 0, 1,0,0,0, 32'hB0,         4'd11, 4'b0111};
      tbl[12] = '{0,0,1,32'hC0,         4'b0000, 4'b1101, 2'b11, 1,0,0,0, 4'd12, 1, 1,0,0,1, 32'hC0,         4'd12, 4'b0000};
      tbl[13] = '{0,0,1,32'hD0,         4'b0000, 4'b0011, 2'b00, 0,1,0,0, 4'd13, 1, 1,1,0,0, 32'hD0,         4'd13, 4'b0000};
      tbl[14] = '{1,1,1,32'hE0,         4'b1111, 4'b1110, 2'b11, 1,1,1,0, 4'd14, 1, 0,0,0,0, 32'hD0,         4'd13, 4'b0000};
      tbl[15] = '{0,1,1,32'hF0,         4'b1111, 4'b1110, 2'b11, 1,1,1,0, 4'd14, 1, 0,0,0,0, 32'hD0,         4'd13, 4'b0000};
      tbl[16] = '{0,0,1,32'h100,        4'b0010, 4'b1001, 2'b01, 0,1,0,0, 4'd1,  1, 1,1,0,0, 32'h100,        4'd1,  4'b0010};
      tbl[17] = '{0,0,1,32'h110,        4'b0000, 4'b0010, 2'b00, 0,0,1,0, 4'd2,  1, 1,0,1,0, 32'h110,        4'd2,  4'b0010};

      reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
      ALUResult = '0; WriteData = '0; ALUFlags = '0; Cond = '0; FlagW = '0;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; WA3 = '0;

      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("por");
      reset = 1'b1;

      foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

      // Stall: capture one instruction, hold three cycles with changing inputs
      v = '{0,0,1,32'h77, 4'b0110, 4'b1110, 2'b11, 0,1,0,0, 4'd5, 1, 1,1,0,0, 32'h77, 4'd5, 4'b0110};
      run_vec(v, "stall_load");
      for (int k = 0; k < 3; k++) begin
         v = '{1,0,1,32'hA000 + k, 4'b1111, 4'b1110, 2'b11, 1,1,1,0, 4'(k+8), 1, 1,1,0,0, 32'h77, 4'd5, 4'b0110};
         run_vec(v, $sformatf("stall%0d", k));
      end
      v = '{0,0,1,32'h99, 4'b1000, 4'b1110, 2'b10, 0,0,1,0, 4'd6, 1, 1,0,1,0, 32'h99, 4'd6, 4'b1010};
      run_vec(v, "stall_release");

      // Reset mid-operation: RegWriteM must drop without waiting for an edge
      v = '{0,0,1,32'h55, 4'b0000, 4'b1110, 2'b00, 0,1,0,0, 4'd7, 1, 1,1,0,0, 32'h55, 4'd7, 4'b1010};
      run_vec(v, "pre_reset");
      #2;
      reset = 1'b0;
      #1;
      chk_reset_state("async_reset");
      @(posedge clk);
      #1;
      chk_reset_state("held_reset");
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      v = '{0,0,1,32'h1234, 4'b0001, 4'b1110, 2'b11, 0,1,0,0, 4'd9, 1, 1,1,0,0, 32'h1234, 4'd9, 4'b0001};
      run_vec(v, "post_reset");
      v = '{0,0,1,32'h4321, 4'b0000, 4'b0110, 2'b00, 1,0,0,0, 4'd14, 1, 1,0,0,1, 32'h4321, 4'd14, 4'b0001};
      run_vec(v, "b2b_vs");

      chk("sb_drained", sb.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
